// File: rtl/conv_enc.sv
// rtl/conv_enc.sv - rate-1/2 K=3 convolutional encoder (G0=111, G1=101) with zero-tail framing
module conv_enc #(
    parameter int FRAME_LEN = 8,
    parameter bit TAIL_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last,
    output logic       busy
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {S_DATA, S_TAIL1, S_TAIL2} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sreg_q, sreg_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [1:0]    out_sym_q, out_sym_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;

    logic          out_free;
    logic          accept;
    logic          frame_end;
    logic          enc_en;
    logic          u;
    logic [CW-1:0] cnt_inc;

    assign out_free  = ~out_valid_q | out_ready;
    assign in_ready  = (state_q == S_DATA) & out_free;
    assign accept    = in_valid & in_ready;
    assign cnt_inc   = bit_cnt_q + 1'b1;
    assign frame_end = in_last | (cnt_inc == CW'(FRAME_LEN));

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        enc_en      = 1'b0;
        u           = 1'b0;

        if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                busy_d = 1'b0;
            end
        end

        case (state_q)
            S_DATA: begin
                if (accept) begin
                    u          = in_bit;
                    enc_en     = 1'b1;
                    busy_d     = 1'b1;
                    bit_cnt_d  = cnt_inc;
                    sreg_d     = {in_bit, sreg_q[1]};
                    out_last_d = 1'b0;
                    if (frame_end) begin
                        if (TAIL_EN) begin
                            state_d = S_TAIL1;
                        end else begin
                            out_last_d = 1'b1;
                            sreg_d     = 2'b00;
                            bit_cnt_d  = '0;
                        end
                    end
                end
            end
            S_TAIL1: begin
                if (out_free) begin
                    enc_en     = 1'b1;
                    sreg_d     = {1'b0, sreg_q[1]};
                    out_last_d = 1'b0;
                    state_d    = S_TAIL2;
                end
            end
            S_TAIL2: begin
                // Second zero flushes the trellis back to state 00.
                if (out_free) begin
                    enc_en     = 1'b1;
                    sreg_d     = 2'b00;
                    out_last_d = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = S_DATA;
                end
            end
            default: state_d = S_DATA;
        endcase

        if (enc_en) begin
            out_valid_d = 1'b1;
            out_sym_d   = {u ^ sreg_q[1] ^ sreg_q[0], u ^ sreg_q[0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DATA;
            sreg_q      <= 2'b00;
            bit_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_conv_enc.sv
// tb/tb_conv_enc.sv - randomized self-checking bench for conv_enc (tail and no-tail instances)
module tb_conv_enc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sel;
    logic       in_valid, in_bit, in_last, out_ready;
    logic       in_ready_t, out_valid_t, out_last_t, busy_t;
    logic       in_ready_n, out_valid_n, out_last_n, busy_n;
    logic [1:0] out_sym_t, out_sym_n;

    conv_enc #(.FRAME_LEN(8), .TAIL_EN(1'b1)) u_tail (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(in_ready_t),
        .in_bit(in_bit), .in_last(in_last),
        .out_valid(out_valid_t), .out_ready(out_ready | sel),
        .out_sym(out_sym_t), .out_last(out_last_t), .busy(busy_t)
    );

    conv_enc #(.FRAME_LEN(8), .TAIL_EN(1'b0)) u_notail (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(in_ready_n),
        .in_bit(in_bit), .in_last(in_last),
        .out_valid(out_valid_n), .out_ready(out_ready | ~sel),
        .out_sym(out_sym_n), .out_last(out_last_n), .busy(busy_n)
    );

    wire       in_ready_s  = sel ? in_ready_n  : in_ready_t;
    wire       out_valid_s = sel ? out_valid_n : out_valid_t;
    wire       out_last_s  = sel ? out_last_n  : out_last_t;
    wire       busy_s      = sel ? busy_n      : busy_t;
    wire [1:0] out_sym_s   = sel ? out_sym_n   : out_sym_t;

    int total = 0;
    int bad   = 0;

    logic [1:0] in_q[$];
    logic [2:0] exp_q[$];
    logic       stalled_prev;
    logic [2:0] held_prev;
    logic       acc_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_in(input logic b, input logic l);
        in_q.push_back({l, b});
    endtask

    task automatic push_exp(input logic [1:0] s, input logic l);
        exp_q.push_back({l, s});
    endtask

    // Reference: each symbol from the bit history u[n], u[n-1], u[n-2] (zero before frame start).
    task automatic add_frame(input logic [7:0] bits, input int len, input bit wl, input bit tail);
        int u[12];
        int n;
        n = tail ? len + 2 : len;
        for (int i = 0; i < 12; i++) u[i] = 0;
        for (int i = 0; i < len; i++) begin
            u[i+2] = int'(bits[i]);
            push_in(bits[i], wl && (i == len - 1));
        end
        for (int i = 0; i < n; i++) begin
            push_exp({1'(u[i+2] ^ u[i+1] ^ u[i]), 1'(u[i+2] ^ u[i])}, i == n - 1);
        end
    endtask

    task automatic add_rand_frame(input bit tail);
        int         len;
        bit         wl;
        logic [7:0] bits;
        len  = $urandom_range(8, 1);
        bits = 8'($urandom);
        wl   = 1'b1;
        if (len == 8) wl = 1'($urandom_range(1));
        add_frame(bits, len, wl, tail);
    endtask

    task automatic step(input int p_valid, input int p_ready);
        logic [2:0] e;
        @(negedge clk);
        out_ready = ($urandom_range(99) < p_ready);
        in_valid  = (in_q.size() != 0) && ($urandom_range(99) < p_valid);
        if (in_q.size() != 0) {in_last, in_bit} = in_q[0];
        else                  {in_last, in_bit} = 2'($urandom);
        #1;
        if (acc_prev) begin
            check("latency_valid", out_valid_s, 1);
            check("busy_set", busy_s, 1);
        end
        if (stalled_prev) begin
            check("stall_valid", out_valid_s, 1);
            check("stall_hold", {out_last_s, out_sym_s}, held_prev);
        end
        if (out_valid_s && !out_ready) check("stall_in_ready", in_ready_s, 0);
        if (out_valid_s && out_ready) begin
            if (exp_q.size() == 0) check("extra_sym", {out_last_s, out_sym_s}, 3'h7 + 1);
            else begin
                e = exp_q.pop_front();
                check("sym", {out_last_s, out_sym_s}, e);
            end
        end
        acc_prev = in_valid && in_ready_s;
        if (acc_prev) void'(in_q.pop_front());
        stalled_prev = out_valid_s && !out_ready;
        held_prev    = {out_last_s, out_sym_s};
    endtask

    task automatic drain(input int p_valid, input int p_ready);
        int budget;
        budget = 20000;
        while ((in_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            step(p_valid, p_ready);
            budget--;
        end
        if (budget == 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("idle_busy", busy_s, 0);
        check("idle_valid", out_valid_s, 0);
        acc_prev     = 1'b0;
        stalled_prev = 1'b0;
    endtask

    task automatic reset_mid;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid_s, 0);
        check("rst_sym", out_sym_s, 0);
        check("rst_last", out_last_s, 0);
        check("rst_busy", busy_s, 0);
        in_q.delete();
        exp_q.delete();
        acc_prev     = 1'b0;
        stalled_prev = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        check("rst_in_ready", in_ready_s, 1);
    endtask

    task automatic reset_after_two(input bit tail);
        int n0;
        int budget;
        add_frame(8'b0000_1111, 4, 1'b1, tail);
        n0     = exp_q.size();
        budget = 100;
        while (exp_q.size() > n0 - 2 && budget > 0) begin
            step(100, 100);
            budget--;
        end
        if (budget == 0) check("pre_reset_timeout", exp_q.size(), n0 - 2);
        reset_mid();
    endtask

    initial begin
        sel = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        acc_prev = 1'b0; stalled_prev = 1'b0; held_prev = '0;
        repeat (3) @(posedge clk);
        #1;
        check("por_valid_t", out_valid_t, 0);
        check("por_busy_t", busy_t, 0);
        check("por_valid_n", out_valid_n, 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("por_in_ready_t", in_ready_t, 1);
        check("por_in_ready_n", in_ready_n, 1);

        // Basic frame 1,0,1,1 with tail.
        push_in(1, 0); push_in(0, 0); push_in(1, 0); push_in(1, 1);
        push_exp(2'b11, 0); push_exp(2'b10, 0); push_exp(2'b00, 0);
        push_exp(2'b01, 0); push_exp(2'b01, 0); push_exp(2'b11, 1);
        drain(100, 100);

        // Single-bit frame.
        push_in(1, 1);
        push_exp(2'b11, 0); push_exp(2'b10, 0); push_exp(2'b11, 1);
        drain(100, 100);

        // Length limit with no in_last, then a fresh frame from state 00.
        for (int i = 0; i < 8; i++) push_in(0, 0);
        for (int i = 0; i < 10; i++) push_exp(2'b00, i == 9);
        push_in(1, 1);
        push_exp(2'b11, 0); push_exp(2'b10, 0); push_exp(2'b11, 1);
        drain(100, 100);

        // Stall on the second symbol of the basic frame.
        push_in(1, 0); push_in(0, 0); push_in(1, 0); push_in(1, 1);
        push_exp(2'b11, 0); push_exp(2'b10, 0); push_exp(2'b00, 0);
        push_exp(2'b01, 0); push_exp(2'b01, 0); push_exp(2'b11, 1);
        step(100, 100);
        step(100, 100);
        for (int i = 0; i < 3; i++) begin
            step(100, 0);
            check("stall_sym", out_sym_s, 2'b10);
        end
        drain(100, 100);

        for (int i = 0; i < 40; i++) add_rand_frame(1'b1);
        drain(70, 60);

        reset_after_two(1'b1);
        push_in(1, 1);
        push_exp(2'b11, 0); push_exp(2'b10, 0); push_exp(2'b11, 1);
        drain(100, 100);

        // No-tail instance.
        sel = 1'b1;
        push_in(1, 0); push_in(1, 1);
        push_exp(2'b11, 0); push_exp(2'b01, 1);
        push_in(1, 1);
        push_exp(2'b11, 1);
        drain(100, 100);

        for (int i = 0; i < 8; i++) push_in(1'(i % 2), 0);
        add_frame(8'b1010_1010, 8, 1'b0, 1'b0);
        void'(in_q.pop_back());
        in_q = in_q[8:$];
        in_q = {in_q, in_q};
        in_q.delete();
        exp_q.delete();
        add_frame(8'b0110_1101, 8, 1'b0, 1'b0);
        drain(100, 100);

        reset_after_two(1'b0);
        push_in(1, 1);
        push_exp(2'b11, 1);
        drain(100, 100);

        for (int i = 0; i < 40; i++) add_rand_frame(1'b0);
        drain(70, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
